dma_mem_txn_monitor: RTL and testbench

Synthesizable, parametrised per-PE monitor that observes the DMA↔memory-controller handshakes of every streaming-ops lane and classifies write, read-request and read-response events. It packs them into trace records, arbitrates them round-robin into a trace FIFO, and tracks per-lane outstanding reads with sticky protocol-error flags. One instance sits beside each PE, tapping the `dma_cont` memory-side signals. It replaces per-lane hierarchical testbench probes with an on-die, mode-selectable capture path.

---
 rtl/dma_mon_pkg.sv | 41 ++++
 rtl/dma_mem_txn_monitor_if.sv | 32 +++
 rtl/dma_mon_fifo.sv | 55 +++++
 rtl/dma_mem_txn_monitor.sv | 203 ++++++++++++++++++++
 tb/tb_dma_mem_txn_monitor.sv | 329 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dma_mon_pkg.sv
// Shared types for the DMA/memory-controller transaction monitor: event kinds,
// capture modes, the default-width trace record and small decode helpers.
package dma_mon_pkg;

    localparam int DROP_CNT_W = 16;

    // Widths of the record layout at the default monitor parameters
    localparam int DEF_LANE_W = 5;
    localparam int DEF_ADDR_W = 24;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        KIND_NONE = 2'b00,
        KIND_WR   = 2'b01,
        KIND_RQ   = 2'b10,
        KIND_RS   = 2'b11
    } dma_mon_kind_e;

    typedef enum logic [1:0] {
        MODE_OFF = 2'b00,
        MODE_WR  = 2'b01,
        MODE_RD  = 2'b10,
        MODE_ALL = 2'b11
    } dma_mon_mode_e;

    typedef struct packed {
        logic [DEF_LANE_W-1:0] lane;
        dma_mon_kind_e         kind;
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_DATA_W-1:0] data;
    } dma_mon_record_t;

    function automatic logic mode_has_wr(input dma_mon_mode_e mode);
        return (mode == MODE_WR) || (mode == MODE_ALL);
    endfunction

    function automatic logic mode_has_rd(input dma_mon_mode_e mode);
        return (mode == MODE_RD) || (mode == MODE_ALL);
    endfunction

endpackage

// File: rtl/dma_mem_txn_monitor_if.sv
// Per-lane DMA <-> memory-controller handshake bundle tapped by the monitor.
// master drives the bus (DMA/memc side), slave only observes.
interface dma_mem_txn_monitor_if #(
    parameter int NUM_LANES = 32,
    parameter int ADDR_W    = 24,
    parameter int DATA_W    = 32
);
    logic [NUM_LANES-1:0]        dma__memc__write_valid;
    logic [NUM_LANES*ADDR_W-1:0] dma__memc__write_address;
    logic [NUM_LANES*DATA_W-1:0] dma__memc__write_data;
    logic [NUM_LANES-1:0]        memc__dma__write_ready;
    logic [NUM_LANES-1:0]        dma__memc__read_valid;
    logic [NUM_LANES*ADDR_W-1:0] dma__memc__read_address;
    logic [NUM_LANES-1:0]        dma__memc__read_pause;
    logic [NUM_LANES-1:0]        memc__dma__read_ready;
    logic [NUM_LANES*DATA_W-1:0] memc__dma__read_data;
    logic [NUM_LANES-1:0]        memc__dma__read_data_valid;

    modport master (
        output dma__memc__write_valid, dma__memc__write_address, dma__memc__write_data,
        output memc__dma__write_ready,
        output dma__memc__read_valid, dma__memc__read_address, dma__memc__read_pause,
        output memc__dma__read_ready, memc__dma__read_data, memc__dma__read_data_valid
    );

    modport slave (
        input dma__memc__write_valid, dma__memc__write_address, dma__memc__write_data,
        input memc__dma__write_ready,
        input dma__memc__read_valid, dma__memc__read_address, dma__memc__read_pause,
        input memc__dma__read_ready, memc__dma__read_data, memc__dma__read_data_valid
    );
endinterface

// File: rtl/dma_mon_fifo.sv
// Synchronous FIFO for trace records; DEPTH must be a power of two so the
// pointers wrap naturally. A push while full is accepted only alongside a pop.
module dma_mon_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset_poweron,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign full      = (count_r == (AW+1)'(DEPTH));
    assign empty     = (count_r == {(AW+1){1'b0}});
    assign do_pop_s  = pop & ~empty;
    assign do_push_s = push & (~full | do_pop_s);
    assign rdata     = mem_r[rd_ptr_r];

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (!reset_poweron) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else begin
            if (do_push_s) wr_ptr_r <= wr_ptr_r + 1'b1;
            else           wr_ptr_r <= wr_ptr_r;
            if (do_pop_s)  rd_ptr_r <= rd_ptr_r + 1'b1;
            else           rd_ptr_r <= rd_ptr_r;
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage array; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (do_push_s) mem_r[wr_ptr_r] <= wdata;
    end

endmodule

// File: rtl/dma_mem_txn_monitor.sv
// Per-PE monitor: classifies lane handshakes into trace records, stages one per
// lane, arbitrates round-robin into a trace FIFO and tracks outstanding reads.
module dma_mem_txn_monitor
    import dma_mon_pkg::*;
#(
    parameter int  NUM_LANES       = 32,
    parameter int  ADDR_W          = 24,
    parameter int  DATA_W          = 32,
    parameter int  FIFO_DEPTH      = 16,
    parameter int  MAX_OUTSTANDING = 8,
    localparam int LANE_W          = $clog2(NUM_LANES),
    localparam int REC_W           = LANE_W + 2 + ADDR_W + DATA_W
) (
    input  logic                  clk,
    input  logic                  reset_poweron,
    input  logic [1:0]            cfg_mode,
    dma_mem_txn_monitor_if.slave  tap,
    output logic                  trace_valid,
    input  logic                  trace_ready,
    output logic [REC_W-1:0]      trace_record,
    output logic [DROP_CNT_W-1:0] drop_count,
    output logic [NUM_LANES-1:0]  err_underflow,
    output logic [NUM_LANES-1:0]  err_overflow
);
    localparam int              CNT_W   = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

    dma_mon_mode_e              mode_s;
    logic                       cap_wr_en_s;
    logic                       cap_rd_en_s;
    logic [NUM_LANES-1:0]       stage_occ_s;
    logic [NUM_LANES*REC_W-1:0] stage_rec_s;
    logic [2*NUM_LANES-1:0]     lane_drop_s;
    logic [NUM_LANES-1:0]       grant_s;
    logic                       grant_any_s;
    logic [LANE_W-1:0]          grant_idx_s;
    logic [LANE_W:0]            cand_s;
    logic [LANE_W-1:0]          rr_ptr_r;
    logic                       fifo_full_s;
    logic                       fifo_empty_s;
    logic [REC_W-1:0]           fifo_rdata_s;
    logic [31:0]                drop_sum_s;
    logic [31:0]                drop_next_s;
    logic [DROP_CNT_W-1:0]      drop_sat_s;
    logic [DROP_CNT_W-1:0]      drop_count_r;

    assign mode_s      = dma_mon_mode_e'(cfg_mode);
    assign cap_wr_en_s = mode_has_wr(mode_s);
    assign cap_rd_en_s = mode_has_rd(mode_s);

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        logic              ev_wr_s, ev_rq_s, ev_rs_s;
        logic              cap_wr_s, cap_rq_s, cap_rs_s;
        logic [1:0]        n_cap_s;
        logic              win_s, load_s, blocked_s;
        logic [REC_W-1:0]  win_rec_s;
        logic              vld_r;
        logic [REC_W-1:0]  rec_r;
        logic [CNT_W-1:0]  cnt_r;
        logic              unf_r, ovf_r;

        assign ev_wr_s  = tap.dma__memc__write_valid[i] & tap.memc__dma__write_ready[i];
        assign ev_rq_s  = tap.dma__memc__read_valid[i] & tap.memc__dma__read_ready[i]
                        & ~tap.dma__memc__read_pause[i];
        assign ev_rs_s  = tap.memc__dma__read_data_valid[i];
        assign cap_wr_s = ev_wr_s & cap_wr_en_s;
        assign cap_rq_s = ev_rq_s & cap_rd_en_s;
        assign cap_rs_s = ev_rs_s & cap_rd_en_s;

        assign n_cap_s   = {1'b0, cap_wr_s} + {1'b0, cap_rq_s} + {1'b0, cap_rs_s};
        assign win_s     = cap_wr_s | cap_rq_s | cap_rs_s;
        // A granted stage is vacated this cycle, so it can take a new winner
        assign load_s    = win_s & (~vld_r | grant_s[i]);
        assign blocked_s = win_s & vld_r & ~grant_s[i];

        assign lane_drop_s[2*i +: 2]         = (win_s ? (n_cap_s - 2'd1) : 2'd0) + {1'b0, blocked_s};
        assign stage_occ_s[i]                = vld_r;
        assign stage_rec_s[i*REC_W +: REC_W] = rec_r;
        assign err_underflow[i]              = unf_r;
        assign err_overflow[i]               = ovf_r;

        // Winner record, WR over RQ over RS
        always_comb begin
            win_rec_s = {REC_W{1'b0}};
            if (cap_wr_s) begin
                win_rec_s = {LANE_W'(i), KIND_WR,
                             tap.dma__memc__write_address[i*ADDR_W +: ADDR_W],
                             tap.dma__memc__write_data[i*DATA_W +: DATA_W]};
            end else if (cap_rq_s) begin
                win_rec_s = {LANE_W'(i), KIND_RQ,
                             tap.dma__memc__read_address[i*ADDR_W +: ADDR_W], {DATA_W{1'b0}}};
            end else if (cap_rs_s) begin
                win_rec_s = {LANE_W'(i), KIND_RS,
                             {ADDR_W{1'b0}}, tap.memc__dma__read_data[i*DATA_W +: DATA_W]};
            end else begin
                win_rec_s = {REC_W{1'b0}};
            end
        end

        // Single-entry staging register
        always_ff @(posedge clk) begin
            if (!reset_poweron) begin
                vld_r <= 1'b0;
                rec_r <= {REC_W{1'b0}};
            end else if (load_s) begin
                vld_r <= 1'b1;
                rec_r <= win_rec_s;
            end else if (grant_s[i]) begin
                vld_r <= 1'b0;
                rec_r <= rec_r;
            end else begin
                vld_r <= vld_r;
                rec_r <= rec_r;
            end
        end

        // Outstanding-read counter with sticky protocol errors; mode-independent
        always_ff @(posedge clk) begin
            if (!reset_poweron) begin
                cnt_r <= {CNT_W{1'b0}};
                unf_r <= 1'b0;
                ovf_r <= 1'b0;
            end else if (ev_rq_s && !ev_rs_s) begin
                if (cnt_r == CNT_MAX) ovf_r <= 1'b1;
                else                  cnt_r <= cnt_r + 1'b1;
            end else if (ev_rs_s && !ev_rq_s) begin
                if (cnt_r == {CNT_W{1'b0}}) unf_r <= 1'b1;
                else                        cnt_r <= cnt_r - 1'b1;
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    // Round-robin search starting at the lane after the previous grant
    always_comb begin
        grant_any_s = 1'b0;
        grant_idx_s = {LANE_W{1'b0}};
        cand_s      = {(LANE_W+1){1'b0}};
        for (int k = 0; k < NUM_LANES; k++) begin
            cand_s = {1'b0, rr_ptr_r} + (LANE_W+1)'(k);
            if (cand_s >= (LANE_W+1)'(NUM_LANES)) cand_s = cand_s - (LANE_W+1)'(NUM_LANES);
            else                                  cand_s = cand_s;
            if (!grant_any_s && !fifo_full_s && stage_occ_s[cand_s[LANE_W-1:0]]) begin
                grant_any_s = 1'b1;
                grant_idx_s = cand_s[LANE_W-1:0];
            end else begin
                grant_any_s = grant_any_s;
            end
        end
    end

    // One-hot grant vector back to the stages
    always_comb begin
        grant_s = {NUM_LANES{1'b0}};
        if (grant_any_s) grant_s[grant_idx_s] = 1'b1;
        else             grant_s = {NUM_LANES{1'b0}};
    end

    // Arbiter pointer
    always_ff @(posedge clk) begin
        if (!reset_poweron)                                  rr_ptr_r <= {LANE_W{1'b0}};
        else if (grant_any_s && (grant_idx_s == LANE_W'(NUM_LANES - 1))) rr_ptr_r <= {LANE_W{1'b0}};
        else if (grant_any_s)                                rr_ptr_r <= grant_idx_s + 1'b1;
        else                                                 rr_ptr_r <= rr_ptr_r;
    end

    // Sum every drop seen this cycle and saturate
    always_comb begin
        drop_sum_s = 32'd0;
        for (int k = 0; k < NUM_LANES; k++) begin
            drop_sum_s = drop_sum_s + {30'd0, lane_drop_s[2*k +: 2]};
        end
        drop_next_s = 32'(drop_count_r) + drop_sum_s;
        if (drop_next_s > 32'({DROP_CNT_W{1'b1}})) drop_sat_s = {DROP_CNT_W{1'b1}};
        else                                       drop_sat_s = drop_next_s[DROP_CNT_W-1:0];
    end

    // Drop counter register
    always_ff @(posedge clk) begin
        if (!reset_poweron) drop_count_r <= {DROP_CNT_W{1'b0}};
        else                drop_count_r <= drop_sat_s;
    end

    dma_mon_fifo #(
        .WIDTH (REC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk           (clk),
        .reset_poweron (reset_poweron),
        .push          (grant_any_s),
        .wdata         (stage_rec_s[grant_idx_s*REC_W +: REC_W]),
        .pop           (trace_valid & trace_ready),
        .rdata         (fifo_rdata_s),
        .full          (fifo_full_s),
        .empty         (fifo_empty_s)
    );

    assign trace_valid  = ~fifo_empty_s;
    assign trace_record = trace_valid ? fifo_rdata_s : {REC_W{1'b0}};
    assign drop_count   = drop_count_r;

endmodule

// File: tb/tb_dma_mem_txn_monitor.sv
// Scoreboard bench for dma_mem_txn_monitor: directed scenarios plus a throttled
// random phase checked against a spec-level model of records, drops and errors.
module tb_dma_mem_txn_monitor;
    import dma_mon_pkg::*;

    localparam int NL = 32;
    localparam int AW = 24;
    localparam int DW = 32;
    localparam int FD = 16;
    localparam int MO = 8;
    localparam int RW = 5 + 2 + AW + DW;

    logic          clk = 1'b0;
    logic          reset_poweron = 1'b0;
    logic [1:0]    cfg_mode = 2'b00;
    logic          trace_valid;
    logic          trace_ready = 1'b0;
    logic [RW-1:0] trace_record;
    logic [15:0]   drop_count;
    logic [NL-1:0] err_underflow;
    logic [NL-1:0] err_overflow;

    always #5 clk = ~clk;

    dma_mem_txn_monitor_if #(.NUM_LANES(NL), .ADDR_W(AW), .DATA_W(DW)) tap ();

    dma_mem_txn_monitor #(
        .NUM_LANES(NL), .ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(FD), .MAX_OUTSTANDING(MO)
    ) dut (
        .clk           (clk),
        .reset_poweron (reset_poweron),
        .cfg_mode      (cfg_mode),
        .tap           (tap),
        .trace_valid   (trace_valid),
        .trace_ready   (trace_ready),
        .trace_record  (trace_record),
        .drop_count    (drop_count),
        .err_underflow (err_underflow),
        .err_overflow  (err_overflow)
    );

    int            n_cmp = 0;
    int            n_fail = 0;
    logic [RW-1:0] exp_q[$];
    int            issued = 0;
    int            popped = 0;
    int            exp_drops = 0;
    int            out_cnt[NL];
    logic [NL-1:0] m_unf = '0;
    logic [NL-1:0] m_ovf = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [RW-1:0] mk(input int ln, input logic [1:0] kind,
                                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        dma_mon_record_t r;
        logic [31:0] l;
        l      = 32'(ln);
        r.lane = l[4:0];
        r.kind = dma_mon_kind_e'(kind);
        r.addr = a;
        r.data = d;
        return r;
    endfunction

    // Scoreboard monitor: every presented head must match the oldest expected record
    always @(negedge clk) begin
        if (reset_poweron && trace_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_record: got %h expected none", trace_record);
            end else begin
                check(trace_ready ? "record_pop" : "record_hold", 64'(trace_record), 64'(exp_q[0]));
                if (trace_ready) begin
                    void'(exp_q.pop_front());
                    popped++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        tap.dma__memc__write_valid     = '0;
        tap.dma__memc__write_address   = '0;
        tap.dma__memc__write_data      = '0;
        tap.memc__dma__write_ready     = '0;
        tap.dma__memc__read_valid      = '0;
        tap.dma__memc__read_address    = '0;
        tap.dma__memc__read_pause      = '0;
        tap.memc__dma__read_ready      = '0;
        tap.memc__dma__read_data       = '0;
        tap.memc__dma__read_data_valid = '0;
    endtask

    // Drive one lane for the next edge and apply the capture/counter rules to the model
    task automatic issue(input int ln, input logic wv, input logic wr, input logic [AW-1:0] wa,
                         input logic [DW-1:0] wd, input logic rv, input logic rr, input logic rp,
                         input logic [AW-1:0] ra, input logic rdv, input logic [DW-1:0] rd);
        logic [RW-1:0] caps[$];
        logic          rq;
        tap.dma__memc__write_valid[ln]           = wv;
        tap.memc__dma__write_ready[ln]           = wr;
        tap.dma__memc__write_address[ln*AW +: AW] = wa;
        tap.dma__memc__write_data[ln*DW +: DW]    = wd;
        tap.dma__memc__read_valid[ln]            = rv;
        tap.memc__dma__read_ready[ln]            = rr;
        tap.dma__memc__read_pause[ln]            = rp;
        tap.dma__memc__read_address[ln*AW +: AW]  = ra;
        tap.memc__dma__read_data_valid[ln]       = rdv;
        tap.memc__dma__read_data[ln*DW +: DW]     = rd;
        rq = rv && rr && !rp;
        if (cfg_mode[0] && wv && wr) caps.push_back(mk(ln, 2'b01, wa, wd));
        if (cfg_mode[1] && rq)       caps.push_back(mk(ln, 2'b10, ra, 32'h0));
        if (cfg_mode[1] && rdv)      caps.push_back(mk(ln, 2'b11, 24'h0, rd));
        if (caps.size() > 0) begin
            exp_q.push_back(caps[0]);
            issued++;
            exp_drops += caps.size() - 1;
        end
        if (rq && !rdv) begin
            if (out_cnt[ln] == MO) m_ovf[ln] = 1'b1;
            else                   out_cnt[ln]++;
        end else if (rdv && !rq) begin
            if (out_cnt[ln] == 0) m_unf[ln] = 1'b1;
            else                  out_cnt[ln]--;
        end
    endtask

    task automatic issue_wr(input int ln, input logic [AW-1:0] a, input logic [DW-1:0] d);
        issue(ln, 1'b1, 1'b1, a, d, 1'b0, 1'b0, 1'b0, 24'h0, 1'b0, 32'h0);
    endtask

    task automatic model_clear();
        exp_q.delete();
        issued = 0;
        popped = 0;
        exp_drops = 0;
        m_unf = '0;
        m_ovf = '0;
        for (int i = 0; i < NL; i++) out_cnt[i] = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset_poweron = 1'b0;
        tick();
        tick();
        reset_poweron = 1'b1;
        model_clear();
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        trace_ready = 1'b1;
        while (exp_q.size() != 0 && t < 300) begin
            tick();
            t++;
        end
        check({name, "_drained"}, 64'(exp_q.size()), 64'd0);
        repeat (4) tick();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        model_clear();
        tick();
        tick();
        check("reset_valid", 64'(trace_valid), 64'd0);
        check("reset_record", 64'(trace_record), 64'd0);
        check("reset_drop", 64'(drop_count), 64'd0);
        check("reset_err", {err_underflow, err_overflow}, 64'd0);

        // Single write, latency to trace_valid
        do_reset();
        cfg_mode = 2'b11;
        trace_ready = 1'b1;
        issue_wr(5, 24'h000100, 32'hDEADBEEF);
        tick();
        idle_inputs();
        @(negedge clk);
        check("latency_edge_n", 64'(trace_valid), 64'd0);
        @(negedge clk);
        check("latency_edge_n1", 64'(trace_valid), 64'd1);
        @(posedge clk);
        #1;
        drain("single_wr");

        // Three lanes at once leave in round-robin order from lane 0
        do_reset();
        cfg_mode = 2'b11;
        issue_wr(0, 24'h000010, 32'h00000A00);
        issue_wr(3, 24'h000013, 32'h00000A03);
        issue_wr(31, 24'h00001F, 32'h00000A1F);
        tick();
        idle_inputs();
        drain("rr_order");
        check("rr_drop", 64'(drop_count), 64'd0);

        // WR and RQ together on lane 2: WR wins, RQ dropped but counted outstanding
        do_reset();
        cfg_mode = 2'b11;
        issue(2, 1'b1, 1'b1, 24'h000222, 32'h22222222, 1'b1, 1'b1, 1'b0, 24'h000333, 1'b0, 32'h0);
        tick();
        idle_inputs();
        drain("wr_rq");
        check("wr_rq_drop", 64'(drop_count), 64'd1);
        issue(2, 1'b0, 1'b0, 24'h0, 32'h0, 1'b0, 1'b0, 1'b0, 24'h0, 1'b1, 32'h12345678);
        tick();
        idle_inputs();
        tick();
        check("outstanding_one", 64'(err_underflow[2]), 64'd0);
        issue(2, 1'b0, 1'b0, 24'h0, 32'h0, 1'b0, 1'b0, 1'b0, 24'h0, 1'b1, 32'h9ABCDEF0);
        tick();
        idle_inputs();
        check("underflow_lane2", 64'(err_underflow[2]), 64'd1);
        drain("wr_rq_rs");

        // Overflow on lane 7 in write-only mode, then underflow on lane 8
        do_reset();
        cfg_mode = 2'b01;
        for (int i = 0; i < 9; i++) begin
            idle_inputs();
            issue(7, 1'b0, 1'b0, 24'h0, 32'h0, 1'b1, 1'b1, 1'b0, 24'(i), 1'b0, 32'h0);
            tick();
            if (i == 7) check("ovf_after_8", 64'(err_overflow[7]), 64'd0);
        end
        idle_inputs();
        check("ovf_after_9", 64'(err_overflow[7]), 64'd1);
        issue(8, 1'b0, 1'b0, 24'h0, 32'h0, 1'b0, 1'b0, 1'b0, 24'h0, 1'b1, 32'h55);
        tick();
        idle_inputs();
        check("unf_lane8", 64'(err_underflow[8]), 64'd1);
        check("err_vectors", {err_underflow, err_overflow}, {m_unf, m_ovf});
        repeat (5) tick();
        drain("mode01");

        // Backpressure: 20 writes into a 16-deep FIFO plus one stage
        do_reset();
        cfg_mode = 2'b11;
        trace_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            idle_inputs();
            issue_wr(4, 24'(i), $urandom());
            if (i >= 17) begin
                void'(exp_q.pop_back());
                exp_drops++;
            end
            tick();
        end
        idle_inputs();
        repeat (3) tick();
        check("bp_drop", 64'(drop_count), 64'd3);
        check("bp_valid", 64'(trace_valid), 64'd1);
        check("bp_expected", 64'(exp_q.size()), 64'd17);
        drain("backpressure");

        // Reset with records queued discards them silently
        do_reset();
        cfg_mode = 2'b11;
        trace_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            idle_inputs();
            issue_wr(9, 24'h900 + 24'(i), 32'hC0DE0000 + 32'(i));
            tick();
        end
        idle_inputs();
        repeat (2) tick();
        reset_poweron = 1'b0;
        tick();
        reset_poweron = 1'b1;
        model_clear();
        @(negedge clk);
        check("mid_reset_valid", 64'(trace_valid), 64'd0);
        check("mid_reset_drop", 64'(drop_count), 64'd0);
        check("mid_reset_record", 64'(trace_record), 64'd0);
        @(posedge clk);
        #1;
        issue_wr(1, 24'h00ABCD, 32'hFACEFEED);
        tick();
        idle_inputs();
        drain("post_reset");

        // Random traffic, throttled so the FIFO can never fill
        do_reset();
        cfg_mode = 2'b11;
        for (int c = 0; c < 800; c++) begin
            int ln;
            idle_inputs();
            if ($urandom_range(0, 49) == 0) cfg_mode = 2'($urandom_range(0, 3));
            trace_ready = ($urandom_range(0, 9) < 7);
            if ((issued - popped) <= 14 && $urandom_range(0, 3) != 0) begin
                ln = ($urandom_range(0, 3) == 0) ? $urandom_range(0, NL - 1) : $urandom_range(0, 3);
                issue(ln, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 24'($urandom()),
                      $urandom(), 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 2) != 0),
                      1'($urandom_range(0, 3) == 0), 24'($urandom()),
                      1'($urandom_range(0, 2) == 0), $urandom());
            end
            tick();
        end
        idle_inputs();
        drain("random");
        check("random_drop", 64'(drop_count), 64'(exp_drops));
        check("random_underflow", 64'(err_underflow), 64'(m_unf));
        check("random_overflow", 64'(err_overflow), 64'(m_ovf));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
